// File: rtl/i2c_master_arbiter_pkg.sv
// Shared types and widths for the i2c_master arbitration slice.
package i2c_master_arbiter_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } arb_state_e;

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester-side and master-side signals of the i2c_master arbiter.
interface i2c_master_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  import i2c_master_arbiter_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_rw;
  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [I2C_DATA_W-1:0]         rsp_rdata;
  logic                          rsp_err;
  logic                          busy;
  logic                          m_start;
  logic [I2C_ADDR_W-1:0]         m_addr;
  logic                          m_rw;
  logic [I2C_DATA_W-1:0]         m_data_send;
  logic                          m_done;
  logic [I2C_DATA_W-1:0]         m_data_recv;

  // The arbiter itself: serves requesters and drives the shared i2c_master.
  modport master (
    input  req_valid, req_addr, req_rw, req_wdata, m_done, m_data_recv,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output m_start, m_addr, m_rw, m_data_send
  );

  // Environment: requesters plus the i2c_master.
  modport slave (
    output req_valid, req_addr, req_rw, req_wdata, m_done, m_data_recv,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  m_start, m_addr, m_rw, m_data_send
  );

endinterface

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned W = $clog2(N);

  logic         found;
  logic [W-1:0] pos;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      pos = W'((32'(last) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = pos;
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters with round-robin grant and a
// WAIT-state watchdog that aborts transactions whose done never arrives.
module i2c_master_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input logic                  clk,
  input logic                  arstn,
  i2c_master_arbiter_if.master bus
);
  import i2c_master_arbiter_pkg::*;

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYC);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYC - 1);

  arb_state_e            state_q, state_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic [IdxW-1:0]       grant_q, grant_d;
  logic [TmrW-1:0]       timer_q, timer_d;
  logic                  done_q;
  logic                  m_start_q, m_start_d;
  logic [I2C_ADDR_W-1:0] m_addr_q, m_addr_d;
  logic                  m_rw_q, m_rw_d;
  logic [I2C_DATA_W-1:0] m_data_q, m_data_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [I2C_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;
  logic [NUM_REQ-1:0]    req_ready;

  logic [NUM_REQ-1:0] gnt;
  logic [IdxW-1:0]    gnt_idx;
  int unsigned        sel;
  logic               done_rise;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req    (bus.req_valid),
    .last   (last_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  // done_q tracks m_done in every state so a level left high is never an edge.
  assign done_rise = bus.m_done & ~done_q;
  assign sel       = 32'(gnt_idx);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    timer_d     = timer_q;
    m_start_d   = 1'b0;
    m_addr_d    = m_addr_q;
    m_rw_d      = m_rw_q;
    m_data_d    = m_data_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = '0;

    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          req_ready = gnt;
          m_addr_d  = bus.req_addr[sel*I2C_ADDR_W +: I2C_ADDR_W];
          m_rw_d    = bus.req_rw[gnt_idx];
          m_data_d  = bus.req_wdata[sel*I2C_DATA_W +: I2C_DATA_W];
          grant_d   = gnt_idx;
          m_start_d = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + TmrW'(1);
        // A real completion in the watchdog's last cycle still counts as success.
        if (done_rise) begin
          rsp_rdata_d = bus.m_data_recv;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          state_d     = StResp;
        end else if (timer_q == TmrLast) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          state_d     = StResp;
        end
      end
      StResp: begin
        last_d  = grant_q;
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= StIdle;
      last_q      <= IdxW'(NUM_REQ - 1);
      grant_q     <= '0;
      timer_q     <= '0;
      done_q      <= 1'b0;
      m_start_q   <= 1'b0;
      m_addr_q    <= '0;
      m_rw_q      <= 1'b0;
      m_data_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      timer_q     <= timer_d;
      done_q      <= bus.m_done;
      m_start_q   <= m_start_d;
      m_addr_q    <= m_addr_d;
      m_rw_q      <= m_rw_d;
      m_data_q    <= m_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.busy        = busy_q;
  assign bus.m_start     = m_start_q;
  assign bus.m_addr      = m_addr_q;
  assign bus.m_rw        = m_rw_q;
  assign bus.m_data_send = m_data_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Randomized bench for i2c_master_arbiter against a transaction-level model of
// round-robin grant order, done-edge completion and watchdog timing.
module tb_i2c_master_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  i2c_master_arbiter_if #(.NUM_REQ(N)) bus ();

  i2c_master_arbiter #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .arstn(arstn),
    .bus  (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int         last_grant;
  bit         pend  [N];
  logic [6:0] p_addr[N];
  logic       p_rw  [N];
  logic [7:0] p_wd  [N];
  bit         done_lvl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = pend[i];
      bus.req_rw[i]            = p_rw[i];
      bus.req_addr[i*7 +: 7]   = p_addr[i];
      bus.req_wdata[i*8 +: 8]  = p_wd[i];
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    pend[i]   = 1'b1;
    p_addr[i] = a;
    p_rw[i]   = rw;
    p_wd[i]   = wd;
  endtask

  function automatic int pick_winner();
    for (int k = 1; k <= N; k++) begin
      if (pend[(last_grant + k) % N]) return (last_grant + k) % N;
    end
    return -1;
  endfunction

  // lat = WAIT cycle (1-based) at which done is raised; 0 = never (watchdog).
  // hold keeps m_done high after completion, making the next entry stale.
  task automatic do_txn(input int lat, input bit hold, input logic [7:0] rdat);
    int         w, k;
    bit         prev, fin, exp_err;
    logic [7:0] cur, exp_rd, ed;
    logic [6:0] ea;
    logic       er;
    w = pick_winner();
    @(negedge clk);
    if (w < 0) begin
      check_eq("winner_none", bus.req_ready, 0);
      return;
    end
    check_eq("req_ready", bus.req_ready, 32'(1) << w);
    check_eq("idle_busy", bus.busy, 0);
    check_eq("idle_rsp_valid", bus.rsp_valid, 0);
    ea = p_addr[w];
    er = p_rw[w];
    ed = p_wd[w];
    @(posedge clk); #1;
    pend[w] = 1'b0;
    drive_reqs();
    @(negedge clk);
    check_eq("start_pulse", bus.m_start, 1);
    check_eq("start_addr", bus.m_addr, ea);
    check_eq("start_rw", bus.m_rw, er);
    check_eq("start_wdata", bus.m_data_send, ed);
    check_eq("start_busy", bus.busy, 1);
    check_eq("start_ready", bus.req_ready, 0);
    prev    = done_lvl;
    fin     = 1'b0;
    k       = 0;
    exp_rd  = '0;
    exp_err = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      if (lat > 0) done_lvl = (k >= lat - 1);
      cur = (lat > 0 && k == lat - 1) ? rdat : 8'($urandom);
      bus.m_done      = done_lvl;
      bus.m_data_recv = cur;
      @(negedge clk);
      check_eq("wait_start_low", bus.m_start, 0);
      check_eq("wait_rsp_low", bus.rsp_valid, 0);
      check_eq("wait_addr_stable", {bus.m_rw, bus.m_addr, bus.m_data_send}, {er, ea, ed});
      if (done_lvl && !prev) begin
        fin     = 1'b1;
        exp_rd  = cur;
        exp_err = 1'b0;
      end else if (k == int'(TO) - 1) begin
        fin     = 1'b1;
        exp_rd  = '0;
        exp_err = 1'b1;
      end
      prev = done_lvl;
      k++;
    end
    @(posedge clk); #1;
    if (!hold) done_lvl = 1'b0;
    bus.m_done = done_lvl;
    @(negedge clk);
    check_eq("rsp_valid", bus.rsp_valid, 32'(1) << w);
    check_eq("rsp_err", bus.rsp_err, exp_err);
    check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
    check_eq("rsp_busy", bus.busy, 1);
    check_eq("rsp_addr_stable", bus.m_addr, ea);
    last_grant = w;
  endtask

  task automatic rand_reqs();
    bit any;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 1) == 1) set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
      else if (pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b0;
      any |= pend[i];
    end
    if (!any) set_req(int'($urandom_range(0, N - 1)), 7'($urandom), 1'($urandom), 8'($urandom));
    drive_reqs();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.busy,
                   bus.m_start, bus.m_addr, bus.m_rw, bus.m_data_send}, 0);
  endtask

  initial begin
    arstn = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; p_addr[i] = '0; p_rw[i] = 1'b0; p_wd[i] = '0;
    end
    drive_reqs();
    done_lvl        = 1'b0;
    bus.m_done      = 1'b0;
    bus.m_data_recv = '0;
    last_grant      = N - 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_values");
    arstn = 1'b1;
    @(posedge clk); #1;

    // Single write from requester 0
    set_req(0, 7'h65, 1'b0, 8'h63);
    drive_reqs();
    do_txn(5, 1'b0, 8'h00);

    // Read from requester 2
    @(posedge clk); #1;
    set_req(2, 7'h50, 1'b1, 8'h00);
    drive_reqs();
    do_txn(3, 1'b0, 8'hA7);

    // Watchdog abort, then a normal transaction with done left high afterwards
    @(posedge clk); #1;
    set_req(1, 7'h11, 1'b1, 8'h00);
    drive_reqs();
    do_txn(0, 1'b0, 8'h00);
    @(posedge clk); #1;
    set_req(3, 7'h22, 1'b0, 8'h44);
    drive_reqs();
    do_txn(4, 1'b1, 8'h3C);

    // Stale done high across RESP/IDLE/START; only a fresh edge completes
    @(posedge clk); #1;
    set_req(0, 7'h33, 1'b1, 8'h00);
    drive_reqs();
    do_txn(6, 1'b0, 8'h5A);

    // Reset in the middle of WAIT
    @(posedge clk); #1;
    set_req(1, 7'h77, 1'b1, 8'h00);
    drive_reqs();
    @(posedge clk); #1;
    pend[1] = 1'b0;
    drive_reqs();
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1 arstn = 1'b0;
    #1;
    check_all_zero("reset_async");
    repeat (3) begin
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    arstn      = 1'b1;
    last_grant = N - 1;
    done_lvl   = 1'b0;

    // All four valid continuously: grants rotate 0,1,2,3,0
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
    drive_reqs();
    for (int t = 0; t < 5; t++) begin
      do_txn(int'($urandom_range(1, 8)), 1'b0, 8'($urandom));
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (!pend[i]) set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
      drive_reqs();
    end
    do_txn(2, 1'b0, 8'h96);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      rand_reqs();
      do_txn(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20)),
             1'($urandom_range(0, 2) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
